acq_sequencer: RTL
==================

Name: acq_sequencer

Overview:
- Normal-clock-domain controller that sequences one capture session: optional fast-clock source switch, clock generator reset and lock wait, acquisition datapath/FIFO reset, settle, run, and stall/fault handling.
- Sits between the SPI register file (start/stop/clock request) and the clock generator and fast-domain synchronizers (clock_select, clkgen_rst, acq_reset, acq_enable).
- Replaces direct register-driven control of those signals.

Parameters:
- RESET_CYCLES, 16: cycles acq_reset (and clkgen_rst in CLKSW) is held; range 1..65535.
- SETTLE_CYCLES, 8: cycles after acq_reset deasserts before acq_enable, covering synchronizer latency; range 1..65535.
- LOCK_TIMEOUT, 65535: maximum cycles in LOCKWAIT before FAULT; range 1..65535.

Ports:
- clk  in  1  normal-domain clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin acquisition
- stop  in  1  one-cycle request to end or abort
- clock_select_req  in  1  requested fast-clock source, sampled on accepted start
- clk_locked  in  1  clock generator lock, already synchronized to clk
- stalled  in  1  FIFO-overflow stall from fast domain, already synchronized
- clock_select  out  1  registered clock source select to clock generator
- clkgen_rst  out  1  clock generator reset
- acq_reset  out  1  fast-domain/FIFO reset request
- acq_enable  out  1  acquisition enable
- busy  out  1  high in any state except IDLE and FAULT
- error  out  1  high in FAULT
- overflow_sticky  out  1  set on stall, cleared on entry to RESET
- state  out  3  current state encoding

Behaviour:
- All outputs are registered. On rst: state=IDLE, and every output (including clock_select, overflow_sticky and the counter) is 0.
- A single 16-bit down counter is loaded on state entry. Each state ends when the counter reaches 0.
- States and encodings: IDLE=0, CLKSW=1, LOCKWAIT=2, RESET=3, SETTLE=4, RUN=5, STALL=6, FAULT=7.
- Priority in every state: stop beats start when both are high in the same cycle.
- IDLE: all controls are 0.
  - On start with clock_select_req != clock_select: latch clock_select<=clock_select_req and go to CLKSW.
  - On start with clock_select_req == clock_select: go to RESET.
- CLKSW: clkgen_rst=1 for RESET_CYCLES cycles, then go to LOCKWAIT.
- LOCKWAIT: clkgen_rst=0.
  - clk_locked=1 goes to RESET.
  - If the counter expires (LOCK_TIMEOUT cycles) without lock, go to FAULT.
  - clk_locked is ignored during the first cycle of LOCKWAIT.
- RESET: acq_reset=1 for RESET_CYCLES cycles. overflow_sticky is cleared on entry. Then go to SETTLE.
- SETTLE: acq_reset=0 for SETTLE_CYCLES cycles, then go to RUN.
- RUN: acq_enable=1.
  - stop goes to IDLE.
  - stalled=1 goes to STALL and sets overflow_sticky.
  - clk_locked=0 goes to FAULT.
  - start is ignored.
- STALL: acq_enable=0.
  - stop goes to IDLE.
  - start goes to RESET. No clock switch occurs; clock_select_req is ignored.
  - overflow_sticky holds until RESET.
- FAULT: error=1 and clkgen_rst=1 (hold the generator in reset).
  - stop goes to IDLE, which clears error and clkgen_rst.
  - start is ignored.
- Abort: stop in CLKSW, LOCKWAIT, RESET or SETTLE goes to IDLE. clkgen_rst, acq_reset and acq_enable are 0 in the next cycle. clock_select keeps its latched value.
- Latency, same clock source: start sampled at edge N gives acq_reset=1 for cycles N+1..N+RESET_CYCLES, then acq_enable=1 from cycle N+1+RESET_CYCLES+SETTLE_CYCLES.
- Exit from RUN: acq_enable falls one cycle after stop or stalled is sampled.
- rst asserted mid-operation returns to IDLE with reset values on the next edge, regardless of state.
- clock_select changes only in IDLE on an accepted start.

Test Plan:
- Defaults, same clock source: start pulse at cycle 10.
  - Required: acq_reset high cycles 11..26, acq_enable rises at cycle 35, busy=1 from 11, state=5.
- Clock switch: clock_select_req=1, start pulse, clk_locked rises 100 cycles after clkgen_rst falls.
  - Required: clock_select=1 the cycle after start, clkgen_rst high 16 cycles, then RESET, SETTLE and RUN in order; acq_enable rises 1+16+8 cycles after lock is sampled.
- Lock timeout: LOCK_TIMEOUT=50, clk_locked held at 0.
  - Required: after 50 LOCKWAIT cycles, state=7, error=1, clkgen_rst=1.
  - Further start pulses are ignored; a stop pulse returns to state=0 with error=0.
- Stall and restart: in RUN, pulse stalled.
  - Required: acq_enable=0 next cycle, state=6, overflow_sticky=1.
  - A subsequent start gives acq_reset=1 and overflow_sticky=0 on entry to RESET, then RUN again.
- Simultaneous events: start and stop high together in IDLE → remains IDLE; together in STALL → goes to IDLE.
  - stop during RESET cycle 5 → acq_reset=0 next cycle, state=0.
- Lock loss and reset: clk_locked drops in RUN → FAULT, acq_enable=0.
  - rst pulsed in SETTLE → every output is 0 and state=0 on the next edge.

Source files
------------

// File: rtl/acq_sequencer.sv
// Capture-session sequencer: optional fast-clock switch, clock generator reset/lock wait,
// acquisition reset, settle, run, and stall/fault handling in the normal clock domain.
module acq_sequencer #(
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned LOCK_TIMEOUT  = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       clock_select_req,
   input  logic       clk_locked,
   input  logic       stalled,
   output logic       clock_select,
   output logic       clkgen_rst,
   output logic       acq_reset,
   output logic       acq_enable,
   output logic       busy,
   output logic       error,
   output logic       overflow_sticky,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLKSW    = 3'd1,
      S_LOCKWAIT = 3'd2,
      S_RESET    = 3'd3,
      S_SETTLE   = 3'd4,
      S_RUN      = 3'd5,
      S_STALL    = 3'd6,
      S_FAULT    = 3'd7
   } state_t;

   // Counters load N-1 on entry so a state lasts exactly N cycles.
   localparam logic [15:0] RESET_LOAD  = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] LOCK_LOAD   = 16'(LOCK_TIMEOUT - 1);

   state_t      cur;
   state_t      nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic        sel_nxt;

   always_comb begin
      nxt     = cur;
      sel_nxt = clock_select;
      cnt_nxt = (cnt == '0) ? '0 : cnt - 16'd1;
      case (cur)
         S_IDLE: begin
            if (!stop && start) begin
               if (clock_select_req != clock_select) begin
                  sel_nxt = clock_select_req;
                  nxt     = S_CLKSW;
               end else begin
                  nxt = S_RESET;
               end
            end
         end
         S_CLKSW: begin
            if (stop)             nxt = S_IDLE;
            else if (cnt == '0)   nxt = S_LOCKWAIT;
         end
         S_LOCKWAIT: begin
            // A still-loaded counter marks the first LOCKWAIT cycle, where lock is not trusted.
            if (stop)                                  nxt = S_IDLE;
            else if (clk_locked && cnt != LOCK_LOAD)   nxt = S_RESET;
            else if (cnt == '0)                        nxt = S_FAULT;
         end
         S_RESET: begin
            if (stop)             nxt = S_IDLE;
            else if (cnt == '0)   nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (stop)             nxt = S_IDLE;
            else if (cnt == '0)   nxt = S_RUN;
         end
         S_RUN: begin
            if (stop)             nxt = S_IDLE;
            else if (stalled)     nxt = S_STALL;
            else if (!clk_locked) nxt = S_FAULT;
         end
         S_STALL: begin
            if (stop)             nxt = S_IDLE;
            else if (start)       nxt = S_RESET;
         end
         S_FAULT: begin
            if (stop)             nxt = S_IDLE;
         end
         default:                 nxt = S_IDLE;
      endcase
      if (nxt != cur) begin
         case (nxt)
            S_CLKSW, S_RESET: cnt_nxt = RESET_LOAD;
            S_LOCKWAIT:       cnt_nxt = LOCK_LOAD;
            S_SETTLE:         cnt_nxt = SETTLE_LOAD;
            default:          cnt_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur             <= S_IDLE;
         cnt             <= '0;
         clock_select    <= 1'b0;
         clkgen_rst      <= 1'b0;
         acq_reset       <= 1'b0;
         acq_enable      <= 1'b0;
         busy            <= 1'b0;
         error           <= 1'b0;
         overflow_sticky <= 1'b0;
      end else begin
         cur          <= nxt;
         cnt          <= cnt_nxt;
         clock_select <= sel_nxt;
         clkgen_rst   <= (nxt == S_CLKSW) || (nxt == S_FAULT);
         acq_reset    <= (nxt == S_RESET);
         acq_enable   <= (nxt == S_RUN);
         busy         <= (nxt != S_IDLE) && (nxt != S_FAULT);
         error        <= (nxt == S_FAULT);
         if (nxt == S_RESET && cur != S_RESET)
            overflow_sticky <= 1'b0;
         else if (cur == S_RUN && nxt == S_STALL)
            overflow_sticky <= 1'b1;
      end
   end

   assign state = cur;

endmodule
